// File: rtl/sym_seq_pkg.sv
// Shared types and constants for the symbol-sequence transmitter.
package sym_seq_pkg;

    localparam int unsigned SYM_W_DEF = 2;
    localparam logic [SYM_W_DEF-1:0] IDLE_SYM = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/sym_seq_buf.sv
// Symbol buffer: DEPTH x SYM_W register file, synchronous write,
// combinational read, asynchronous reset to 00.
module sym_seq_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SYM_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SYM_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [SYM_W-1:0]         rd_data
);

    logic [SYM_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sym_seq_tx.sv
// Symbol-sequence transmitter: replays buffered symbols on X, logs Moore Z.
// Optional feature macro: SYM_SEQ_TX_LOOP_EN (adds LOOP input for repeating passes).
module sym_seq_tx
    import sym_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned HOLD  = 1,
    parameter int unsigned SYM_W = SYM_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     WR_EN,
    input  logic [$clog2(DEPTH)-1:0] WR_ADDR,
    input  logic [SYM_W-1:0]         WR_DATA,
    input  logic [$clog2(DEPTH):0]   LEN,
    input  logic                     START,
    input  logic                     Z,
`ifdef SYM_SEQ_TX_LOOP_EN
    input  logic                     LOOP,
`endif
    output logic [SYM_W-1:0]         X,
    output logic                     X_VALID,
    output logic [DEPTH-1:0]         Z_LOG,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t           state, next_state;
    logic [AW-1:0]    idx, idx_d;
    logic [HW-1:0]    hold, hold_d;
    logic [LW-1:0]    len_q, len_sat;
    logic [SYM_W-1:0] rd_data;
    logic [SYM_W-1:0] x_d;
    logic             x_valid_d, busy_d, done_d;
    logic             in_tx, start_ok, last_hold, last_sym, loop_c, wrap;
    logic             cap_pend;
    logic [AW-1:0]    cap_idx;

`ifdef SYM_SEQ_TX_LOOP_EN
    assign loop_c = LOOP;
`else
    assign loop_c = 1'b0;
`endif

    assign in_tx     = (state == SEND) || (state == DRAIN);
    assign start_ok  = START && !in_tx;
    assign len_sat   = (LEN > LW'(DEPTH)) ? LW'(DEPTH) : LEN;
    assign last_hold = (hold == HW'(HOLD - 1));
    assign last_sym  = (LW'(idx) == (len_q - LW'(1)));
    assign wrap      = (state == SEND) && last_hold && last_sym && loop_c;

    // Buffer is frozen while a sequence is in flight
    sym_seq_buf #(
        .DEPTH (DEPTH),
        .SYM_W (SYM_W)
    ) u_buf (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (WR_EN && !in_tx),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (idx_d),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus symbol index and hold counter
    always_comb begin
        next_state = state;
        idx_d      = idx;
        hold_d     = hold;
        case (state)
            IDLE, FIN: begin
                next_state = IDLE;
                if (START) begin
                    next_state = (len_sat == '0) ? FIN : SEND;
                    idx_d      = '0;
                    hold_d     = '0;
                end
            end
            SEND: begin
                if (last_hold) begin
                    hold_d = '0;
                    if (last_sym) begin
                        idx_d      = '0;
                        next_state = loop_c ? SEND : DRAIN;
                    end else begin
                        idx_d = idx + AW'(1);
                    end
                end else begin
                    hold_d = hold + HW'(1);
                end
            end
            DRAIN:   next_state = FIN;
            default: next_state = IDLE;
        endcase
    end

    // Output values for the coming cycle, registered below
    always_comb begin
        x_d       = SYM_W'(IDLE_SYM);
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (next_state)
            SEND: begin
                x_d       = rd_data;
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
            DRAIN:   busy_d = 1'b1;
            FIN:     done_d = 1'b1;
            default: ;
        endcase
        if (wrap) begin
            done_d = 1'b1;
        end
    end

    // Z for a symbol is taken one cycle after its last hold cycle (Moore lag)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx      <= '0;
            hold     <= '0;
            len_q    <= '0;
            cap_pend <= 1'b0;
            cap_idx  <= '0;
            X        <= '0;
            X_VALID  <= 1'b0;
            Z_LOG    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            idx      <= idx_d;
            hold     <= hold_d;
            cap_pend <= (state == SEND) && last_hold;
            cap_idx  <= idx;
            X        <= x_d;
            X_VALID  <= x_valid_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
            if (start_ok) begin
                len_q <= len_sat;
                Z_LOG <= '0;
            end
            if (cap_pend) begin
                Z_LOG[cap_idx] <= Z;
            end
        end
    end

endmodule

// File: tb/tb_sym_seq_tx.sv
// Bench for sym_seq_tx: two instances (HOLD=1 and HOLD=3), a registered
// (X==10) downstream Z model, and a per-cycle expectation from the timing rules.
module tb_sym_seq_tx;

    localparam int unsigned H0 = 1;
    localparam int unsigned H1 = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en   [2];
    logic [2:0] wr_addr [2];
    logic [1:0] wr_data [2];
    logic [3:0] len     [2];
    logic       start   [2];
    logic       z       [2];
    logic [1:0] x       [2];
    logic       xv      [2];
    logic [7:0] zlog    [2];
    logic       busy    [2];
    logic       done    [2];

    logic [1:0] shadow [2][8];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sym_seq_tx #(.DEPTH(8), .HOLD(H0), .SYM_W(2)) u_h1 (
        .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en[0]), .WR_ADDR(wr_addr[0]),
        .WR_DATA(wr_data[0]), .LEN(len[0]), .START(start[0]), .Z(z[0]),
        .X(x[0]), .X_VALID(xv[0]), .Z_LOG(zlog[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    sym_seq_tx #(.DEPTH(8), .HOLD(H1), .SYM_W(2)) u_h3 (
        .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en[1]), .WR_ADDR(wr_addr[1]),
        .WR_DATA(wr_data[1]), .LEN(len[1]), .START(start[1]), .Z(z[1]),
        .X(x[1]), .X_VALID(xv[1]), .Z_LOG(zlog[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    // Downstream Moore machine stand-in: Z = registered (X == 10)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z[0] <= 1'b0;
            z[1] <= 1'b0;
        end else begin
            z[0] <= (x[0] == 2'b10);
            z[1] <= (x[1] == 2'b10);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input int i, input string tag);
        chk($sformatf("%s_x%0d", tag, i), 32'(x[i]), 32'd0);
        chk($sformatf("%s_xv%0d", tag, i), 32'(xv[i]), 32'd0);
        chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
        chk($sformatf("%s_done%0d", tag, i), 32'(done[i]), 32'd0);
        chk($sformatf("%s_zlog%0d", tag, i), 32'(zlog[i]), 32'd0);
    endtask

    task automatic write_sym(input int i, input int a, input logic [1:0] d);
        wr_en[i]   = 1'b1;
        wr_addr[i] = 3'(a);
        wr_data[i] = d;
        @(negedge clk);
        wr_en[i]   = 1'b0;
        shadow[i][a] = d;
    endtask

    // Called at a negedge; START is driven in the current cycle (cycle 0).
    // Returns at the negedge of the DONE cycle, so a following call starts back-to-back.
    task automatic run_seq(input int i, input int l, input bit poke);
        int h, n, total, pa;
        logic [7:0] zexp;
        logic [1:0] ex;
        logic ev, eb, ed;
        h = (i == 0) ? int'(H0) : int'(H1);
        n = (l > 8) ? 8 : l;
        pa = (n > 0) ? n - 1 : 0;
        zexp = '0;
        for (int k = 0; k < n; k++) zexp[k] = (shadow[i][k] == 2'b10);
        start[i] = 1'b1;
        len[i]   = 4'(l);
        @(negedge clk);
        start[i] = 1'b0;
        total = (n == 0) ? 1 : n * h + 2;
        for (int c = 1; c <= total; c++) begin
            if (c > 1) @(negedge clk);
            ex = 2'b00; ev = 1'b0; eb = 1'b0; ed = 1'b0;
            if (n == 0) begin
                ed = 1'b1;
            end else if (c <= n * h) begin
                ex = shadow[i][(c - 1) / h];
                ev = 1'b1;
                eb = 1'b1;
            end else if (c == n * h + 1) begin
                eb = 1'b1;
            end else begin
                ed = 1'b1;
            end
            chk($sformatf("x_i%0d_l%0d_c%0d", i, l, c), 32'(x[i]), 32'(ex));
            chk($sformatf("xv_i%0d_l%0d_c%0d", i, l, c), 32'(xv[i]), 32'(ev));
            chk($sformatf("busy_i%0d_l%0d_c%0d", i, l, c), 32'(busy[i]), 32'(eb));
            chk($sformatf("done_i%0d_l%0d_c%0d", i, l, c), 32'(done[i]), 32'(ed));
            if (c == 1) chk($sformatf("zclr_i%0d_l%0d", i, l), 32'(zlog[i]), 32'd0);
            if (poke && c == 2) begin
                start[i]   = 1'b1;
                len[i]     = 4'd1;
                wr_en[i]   = 1'b1;
                wr_addr[i] = 3'(pa);
                wr_data[i] = ~shadow[i][pa];
            end else if (poke && c == 3) begin
                start[i] = 1'b0;
                wr_en[i] = 1'b0;
            end
        end
        chk($sformatf("zlog_i%0d_l%0d", i, l), 32'(zlog[i]), 32'(zexp));
    endtask

    initial begin
        int i, l, h, n;
        bit poke;
        logic [1:0] pat [8];
        pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b01; pat[3] = 2'b00;
        pat[4] = 2'b10; pat[5] = 2'b10; pat[6] = 2'b00; pat[7] = 2'b10;
        for (int j = 0; j < 2; j++) begin
            wr_en[j] = 1'b0; wr_addr[j] = '0; wr_data[j] = '0;
            len[j] = '0; start[j] = 1'b0;
            for (int k = 0; k < 8; k++) shadow[j][k] = 2'b00;
        end

        repeat (3) @(negedge clk);
        chk_quiet(0, "rst");
        chk_quiet(1, "rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Reference pattern, HOLD=1, LEN=8
        for (int k = 0; k < 8; k++) write_sym(0, k, pat[k]);
        run_seq(0, 8, 1'b0);
        chk("zlog_ref_pattern", 32'(zlog[0]), 32'h0000_00b0);

        // HOLD=3, LEN=2, then LEN=0 START in the DONE cycle
        write_sym(1, 0, 2'b10);
        write_sym(1, 1, 2'b01);
        run_seq(1, 2, 1'b0);
        chk("zlog_hold3", 32'(zlog[1][1:0]), 32'h1);
        run_seq(1, 0, 1'b0);
        @(negedge clk);

        // LEN saturation with mid-sequence START/WR_EN
        run_seq(0, 12, 1'b1);
        @(negedge clk);
        run_seq(0, 8, 1'b0);
        @(negedge clk);

        // Randomized sequences on both instances
        for (int r = 0; r < 14; r++) begin
            i = int'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) write_sym(i, k, 2'($urandom_range(0, 3)));
            l = int'($urandom_range(0, 12));
            h = (i == 0) ? int'(H0) : int'(H1);
            n = (l > 8) ? 8 : l;
            poke = (n * h >= 4) && ($urandom_range(0, 1) == 1);
            run_seq(i, l, poke);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during cycle 4 of a LEN=8 run
        for (int k = 0; k < 8; k++) write_sym(0, k, 2'b10);
        start[0] = 1'b1;
        len[0]   = 4'd8;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet(0, "abort");
        @(negedge clk);
        chk("abort_nodone", 32'(done[0]), 32'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 8; k++) shadow[j][k] = 2'b00;
        @(negedge clk);
        run_seq(0, 8, 1'b0);
        run_seq(1, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
